// File: rtl/imem_byte_loader.sv
// Boot-time program loader: assembles strobed pad bytes into little-endian 32-bit
// instruction words, writes them to instruction memory and holds the core in reset until released.
module imem_byte_loader #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        byte_in,
    input  logic              byte_stb,
    input  logic              load_en,
    input  logic              start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err_ovf,
    output logic              err_partial
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] WORDS_MAX = CNT_W'(1) << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        stb_q;
    logic [1:0]  byte_cnt;
    logic [23:0] word_q;

    logic stb_rise_c;
    logic full_c;
    logic load_entry_c;
    logic load_exit_c;
    logic accept_c;

    assign stb_rise_c = byte_stb & ~stb_q;
    assign full_c     = (words_loaded == WORDS_MAX);

    // Next-state and per-cycle control; a strobe edge coinciding with load_en falling is dropped
    always_comb begin
        state_next   = state;
        load_entry_c = 1'b0;
        load_exit_c  = 1'b0;
        accept_c     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_en) begin
                    state_next   = ST_LOAD;
                    load_entry_c = 1'b1;
                end else if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (!load_en) begin
                    state_next  = ST_RUN;
                    load_exit_c = 1'b1;
                end else begin
                    accept_c = stb_rise_c;
                end
            end
            ST_RUN: begin
                if (load_en) begin
                    state_next   = ST_LOAD;
                    load_entry_c = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Byte assembly, memory write port and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stb_q        <= 1'b0;
            byte_cnt     <= 2'd0;
            word_q       <= 24'd0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 32'd0;
            core_rst     <= 1'b1;
            words_loaded <= '0;
            err_ovf      <= 1'b0;
            err_partial  <= 1'b0;
        end else begin
            stb_q    <= byte_stb;
            mem_we   <= 1'b0;
            core_rst <= (state != ST_RUN);

            if (load_entry_c) begin
                byte_cnt     <= 2'd0;
                words_loaded <= '0;
                err_ovf      <= 1'b0;
                err_partial  <= 1'b0;
            end

            if (load_exit_c) begin
                byte_cnt <= 2'd0;
                if (byte_cnt != 2'd0) begin
                    err_partial <= 1'b1;
                end
            end

            if (accept_c) begin
                if (full_c) begin
                    err_ovf <= 1'b1;
                end else if (byte_cnt == 2'd3) begin
                    mem_we       <= 1'b1;
                    mem_addr     <= words_loaded[ADDR_W-1:0];
                    mem_wdata    <= {byte_in, word_q};
                    words_loaded <= words_loaded + CNT_W'(1);
                    byte_cnt     <= 2'd0;
                end else begin
                    case (byte_cnt)
                        2'd0:    word_q[7:0]   <= byte_in;
                        2'd1:    word_q[15:8]  <= byte_in;
                        default: word_q[23:16] <= byte_in;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                end
            end
        end
    end

endmodule
